// File: rtl/rf_read_arbiter.sv
// rtl/rf_read_arbiter.sv - round-robin arbiter for the shared RF read port (accelerator bursts vs host single reads)
// Optional host port enabled by defining RF_READ_ARB_HOST_EN; without it the FSM is IDLE/BURST only.
module rf_read_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 9,
    parameter int BURST_LEN = 16
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_acc_req,
    input  logic [ADDR_W-1:0] in_acc_addr,
    output logic              out_acc_gnt,
    output logic              out_acc_valid,
    output logic [DATA_W-1:0] out_acc_data,
    output logic              out_acc_last,
    input  logic              in_host_req,
    input  logic [ADDR_W-1:0] in_host_addr,
    output logic              out_host_ack,
    output logic [DATA_W-1:0] out_host_data,
    output logic [ADDR_W-1:0] out_rf_addr,
    input  logic [DATA_W-1:0] in_rf_read,
    output logic              out_busy
);

    localparam int                BEAT_W    = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

`ifdef RF_READ_ARB_HOST_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_HOST  = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] beat_nxt;
    logic [ADDR_W-1:0] rf_addr_nxt;
    logic              gnt_nxt;
    logic              valid_nxt;
    logic              last_nxt;
    logic [DATA_W-1:0] acc_data_nxt;
    logic              acc_q;

    assign acc_q    = in_acc_req;
    assign out_busy = (state != ST_IDLE);

`ifdef RF_READ_ARB_HOST_EN
    // prio: 0 = accelerator wins a tie, 1 = host wins a tie
    logic              prio;
    logic              prio_nxt;
    logic              host_q;
    logic              ack_nxt;
    logic [DATA_W-1:0] host_data_nxt;

    // A host request still high during its own ack cycle is the one just served
    assign host_q = in_host_req & ~out_host_ack;
`else
    logic host_unused;

    assign host_unused   = ^{in_host_req, in_host_addr};
    assign out_host_ack  = 1'b0;
    assign out_host_data = '0;
`endif

    // Next-state and next-output decode; strobes default low, data and address hold
    always_comb begin
        state_nxt    = state;
        beat_nxt     = beat;
        rf_addr_nxt  = out_rf_addr;
        gnt_nxt      = 1'b0;
        valid_nxt    = 1'b0;
        last_nxt     = 1'b0;
        acc_data_nxt = out_acc_data;
`ifdef RF_READ_ARB_HOST_EN
        prio_nxt      = prio;
        ack_nxt       = 1'b0;
        host_data_nxt = out_host_data;
`endif
        case (state)
            ST_IDLE: begin
`ifdef RF_READ_ARB_HOST_EN
                if (acc_q && (!host_q || !prio)) begin
                    state_nxt   = ST_BURST;
                    rf_addr_nxt = in_acc_addr;
                    beat_nxt    = '0;
                    gnt_nxt     = 1'b1;
                    prio_nxt    = 1'b1;
                end else if (host_q) begin
                    state_nxt   = ST_HOST;
                    rf_addr_nxt = in_host_addr;
                    prio_nxt    = 1'b0;
                end
`else
                if (acc_q) begin
                    state_nxt   = ST_BURST;
                    rf_addr_nxt = in_acc_addr;
                    beat_nxt    = '0;
                    gnt_nxt     = 1'b1;
                end
`endif
            end
            ST_BURST: begin
                // RF data is combinational from the registered address, so each
                // BURST cycle captures one word and steps the address
                acc_data_nxt = in_rf_read;
                valid_nxt    = 1'b1;
                rf_addr_nxt  = out_rf_addr + ADDR_W'(1);
                beat_nxt     = beat + BEAT_W'(1);
                if (beat == LAST_BEAT) begin
                    last_nxt  = 1'b1;
                    beat_nxt  = '0;
                    state_nxt = ST_IDLE;
                end
            end
`ifdef RF_READ_ARB_HOST_EN
            ST_HOST: begin
                host_data_nxt = in_rf_read;
                ack_nxt       = 1'b1;
                state_nxt     = ST_IDLE;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered datapath and strobes; reset clears everything so an aborted burst never shows last
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            beat          <= '0;
            out_rf_addr   <= '0;
            out_acc_gnt   <= 1'b0;
            out_acc_valid <= 1'b0;
            out_acc_last  <= 1'b0;
            out_acc_data  <= '0;
`ifdef RF_READ_ARB_HOST_EN
            prio          <= 1'b0;
            out_host_ack  <= 1'b0;
            out_host_data <= '0;
`endif
        end else begin
            beat          <= beat_nxt;
            out_rf_addr   <= rf_addr_nxt;
            out_acc_gnt   <= gnt_nxt;
            out_acc_valid <= valid_nxt;
            out_acc_last  <= last_nxt;
            out_acc_data  <= acc_data_nxt;
`ifdef RF_READ_ARB_HOST_EN
            prio          <= prio_nxt;
            out_host_ack  <= ack_nxt;
            out_host_data <= host_data_nxt;
`endif
        end
    end

endmodule
